// File: rtl/scan_sequencer.sv
// Scan sequencer: drives select A / enable E of a 3-to-8 decoder,
// stepping through unmasked positions with a dwell time and a blanking gap.
// Ports: clk, reset (sync, active-high), run (level), step (pulse),
//        mask[7:0] (enabled positions), A[2:0], E, wrap (pulse), busy.
module scan_sequencer #(
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       step,
  input  logic [7:0] mask,
  output logic [2:0] A,
  output logic       E,
  output logic       wrap,
  output logic       busy
);

  localparam int DW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [DW-1:0] DLAST = DW'(PRESCALE - 1);
  localparam logic [BW-1:0] BLAST =
    BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, DWELL, BLANK} state_t;

  state_t        state;
  logic [DW-1:0] dcnt;
  logic [BW-1:0] bcnt;
  // set while running a single step started with run low
  logic          stepping;

  logic [2:0] nxt;
  logic [2:0] sel;
  logic       has;

  // Lowest index above a with its mask bit set, wrapping around;
  // the loop runs downward so the nearest hit wins.
  function automatic logic [2:0] next_up(input logic [2:0] a,
                                         input logic [7:0] m);
    logic [2:0] r;
    logic [2:0] j;
    r = a;
    for (int k = 7; k >= 1; k--) begin
      j = a + 3'(k);
      if (m[j]) r = j;
    end
    return r;
  endfunction

  always_comb begin
    has = |mask;
    nxt = next_up(A, mask);
    sel = mask[A] ? A : nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      A        <= '0;
      E        <= 1'b0;
      wrap     <= 1'b0;
      busy     <= 1'b0;
      dcnt     <= '0;
      bcnt     <= '0;
      stepping <= 1'b0;
    end else begin
      wrap <= 1'b0;
      unique case (state)
        IDLE: begin
          E    <= 1'b0;
          busy <= 1'b0;
          dcnt <= '0;
          bcnt <= '0;
          if ((run || step) && has) begin
            state    <= DWELL;
            A        <= sel;
            E        <= 1'b1;
            busy     <= 1'b1;
            stepping <= !run;
          end
        end
        DWELL: begin
          if (run) stepping <= 1'b0;
          if (!run && !stepping) begin
            state    <= IDLE;
            E        <= 1'b0;
            busy     <= 1'b0;
            dcnt     <= '0;
            bcnt     <= '0;
            stepping <= 1'b0;
          end else if (dcnt == DLAST) begin
            dcnt <= '0;
            if (!has) begin
              state    <= IDLE;
              E        <= 1'b0;
              busy     <= 1'b0;
              stepping <= 1'b0;
            end else begin
              A    <= nxt;
              wrap <= (nxt <= A);
              if (BLANK_CYCLES > 0) begin
                state <= BLANK;
                E     <= 1'b0;
              end else if (stepping && !run) begin
                state    <= IDLE;
                E        <= 1'b0;
                busy     <= 1'b0;
                stepping <= 1'b0;
              end else begin
                E <= 1'b1;
              end
            end
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        BLANK: begin
          if (run) stepping <= 1'b0;
          if (!run && !stepping) begin
            state    <= IDLE;
            E        <= 1'b0;
            busy     <= 1'b0;
            dcnt     <= '0;
            bcnt     <= '0;
            stepping <= 1'b0;
          end else if (bcnt == BLAST) begin
            bcnt <= '0;
            if (run) begin
              state <= DWELL;
              E     <= 1'b1;
            end else begin
              state    <= IDLE;
              E        <= 1'b0;
              busy     <= 1'b0;
              stepping <= 1'b0;
            end
          end else begin
            bcnt <= bcnt + BW'(1);
          end
        end
        default: begin
          state <= IDLE;
          E     <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: two instances (blank gap 2 and no gap)
// checked every cycle against a period-based model plus directed literals.
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [7:0] mask = 8'h00;

  logic [2:0] a1, a0;
  logic       e1, e0, w1, w0, b1, b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scan_sequencer #(.PRESCALE(4), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .mask(mask),
    .A(a1), .E(e1), .wrap(w1), .busy(b1)
  );

  scan_sequencer #(.PRESCALE(4), .BLANK_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .run(run), .step(step), .mask(mask),
    .A(a0), .E(e0), .wrap(w0), .busy(b0)
  );

  typedef struct {
    bit         act;
    bit         sm;
    int         t;
    logic [2:0] A;
    bit         E;
    bit         wrap;
  } ms_t;

  ms_t m1, m0;

  function automatic logic [2:0] nxt(input logic [2:0] a,
                                     input logic [7:0] m);
    for (int j = a + 1; j <= a + 8; j++)
      if (m[j % 8]) return 3'(j % 8);
    return a;
  endfunction

  // One position period is P dwell cycles then B blank cycles; t is the
  // cycle index inside that period, A advances when t passes P-1.
  function automatic ms_t mstep(ms_t s, bit rst, bit r, bit st,
                                logic [7:0] m, int P, int B);
    ms_t n;
    n = s;
    n.wrap = 0;
    if (rst) begin
      n.act = 0; n.sm = 0; n.t = 0; n.A = 0; n.E = 0;
      return n;
    end
    if (!s.act) begin
      n.E = 0;
      if ((r || st) && m != 0) begin
        n.act = 1; n.sm = !r; n.t = 0; n.E = 1;
        n.A = m[s.A] ? s.A : nxt(s.A, m);
      end
      return n;
    end
    if (r) n.sm = 0;
    if (!r && !n.sm) begin
      n.act = 0; n.sm = 0; n.t = 0; n.E = 0;
      return n;
    end
    if (s.t == P - 1) begin
      if (m == 0) begin
        n.act = 0; n.sm = 0; n.t = 0; n.E = 0;
        return n;
      end
      n.A = nxt(s.A, m);
      n.wrap = (n.A <= s.A);
      if (B > 0) begin
        n.t = P; n.E = 0;
      end else if (n.sm) begin
        n.act = 0; n.sm = 0; n.t = 0; n.E = 0;
      end else begin
        n.t = 0; n.E = 1;
      end
    end else if (s.t == P + B - 1) begin
      if (r) begin
        n.t = 0; n.E = 1;
      end else begin
        n.act = 0; n.sm = 0; n.t = 0; n.E = 0;
      end
    end else begin
      n.t = s.t + 1;
      n.E = (n.t < P);
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // advance one clock, step both models, compare both DUTs
  task automatic tick();
    @(posedge clk);
    m1 = mstep(m1, reset, run, step, mask, 4, 2);
    m0 = mstep(m0, reset, run, step, mask, 4, 0);
    #1;
    chk("g2_A", 32'(a1), 32'(m1.A));
    chk("g2_E", 32'(e1), 32'(m1.E));
    chk("g2_wrap", 32'(w1), 32'(m1.wrap));
    chk("g2_busy", 32'(b1), 32'(m1.act));
    chk("g0_A", 32'(a0), 32'(m0.A));
    chk("g0_E", 32'(e0), 32'(m0.E));
    chk("g0_wrap", 32'(w0), 32'(m0.wrap));
    chk("g0_busy", 32'(b0), 32'(m0.act));
  endtask

  initial begin
    int n, idx, wraps, wrap_at, bad, badw, ns, n3;
    logic [2:0] seq [4];
    logic [2:0] saved;
    logic pe, anye, anyb, achg;
    logic [2:0] expa [7];
    logic expe [7];
    logic expb [7];

    m1 = '{default: 0};
    m0 = '{default: 0};

    // reset
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_A", 32'(a1), 0);
    chk("rst_E", 32'(e1), 0);
    chk("rst_wrap", 32'(w1), 0);
    chk("rst_busy", 32'(b1), 0);

    // 1: full scan
    mask = 8'hFF;
    run = 1'b1;
    n = 0;
    while (!e1 && n < 10) begin tick(); n++; end
    chk("t1_first_e", 32'(e1), 1);
    idx = 0; wraps = 0; wrap_at = -1; bad = 0;
    for (int i = 1; i <= 50; i++) begin
      tick();
      idx++;
      if (w1) begin
        wraps++;
        if (wrap_at < 0) wrap_at = idx;
      end
      if (e1 !== ((idx % 6) < 4)) bad++;
      if (a1 !== 3'(((idx + 2) / 6) % 8)) bad++;
    end
    chk("t1_pattern", 32'(bad), 0);
    chk("t1_wrap_cnt", 32'(wraps), 1);
    chk("t1_wrap_at", 32'(wrap_at), 46);

    // 2: masked scan
    run = 1'b0;
    tick(); tick(); tick();
    mask = 8'b0010_0101;
    run = 1'b1;
    pe = 1'b0; ns = 0; bad = 0; badw = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (e1 && !pe && ns < 4) begin seq[ns] = a1; ns++; end
      if (e1 && (a1 inside {3'd1, 3'd3, 3'd4, 3'd6, 3'd7})) bad++;
      if (w1 && a1 != 3'd0) badw++;
      pe = e1;
    end
    chk("t2_nstarts", 32'(ns), 4);
    chk("t2_seq0", 32'(seq[0]), 0);
    chk("t2_seq1", 32'(seq[1]), 2);
    chk("t2_seq2", 32'(seq[2]), 5);
    chk("t2_seq3", 32'(seq[3]), 0);
    chk("t2_masked_A", 32'(bad), 0);
    chk("t2_bad_wrap", 32'(badw), 0);

    // 3: empty mask
    run = 1'b0;
    tick(); tick(); tick();
    saved = m1.A;
    mask = 8'h00;
    run = 1'b1;
    anye = 0; anyb = 0; achg = 0;
    for (int i = 0; i < 9; i++) begin
      step = (i == 4);
      if (i == 6) run = 1'b0;
      tick();
      anye |= e1;
      anyb |= b1;
      achg |= (a1 != saved);
    end
    step = 1'b0;
    chk("t3_E", 32'(anye), 0);
    chk("t3_busy", 32'(anyb), 0);
    chk("t3_A_moved", 32'(achg), 0);

    // 4: stop in DWELL cycle 2 at A=3, then resume
    mask = 8'hFF;
    run = 1'b1;
    n = 0;
    tick();
    while (!(e1 && a1 == 3'd3) && n < 100) begin tick(); n++; end
    chk("t4_found", 32'(e1 && a1 == 3'd3), 1);
    tick(); tick();
    run = 1'b0;
    tick();
    chk("t4_stop_E", 32'(e1), 0);
    chk("t4_stop_busy", 32'(b1), 0);
    chk("t4_stop_A", 32'(a1), 3);
    run = 1'b1;
    n3 = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (e1 && a1 == 3'd3) n3++;
    end
    chk("t4_resume_dwell", 32'(n3), 4);

    // 5: single step from IDLE at A=6
    n = 0;
    while (!(e1 && a1 == 3'd6) && n < 100) begin tick(); n++; end
    run = 1'b0;
    tick();
    chk("t5_idle", 32'(b1), 0);
    chk("t5_idle_A", 32'(a1), 6);
    expe = '{1, 1, 1, 1, 0, 0, 0};
    expa = '{6, 6, 6, 6, 7, 7, 7};
    expb = '{1, 1, 1, 1, 1, 1, 0};
    step = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      step = 1'b0;
      chk($sformatf("t5_E%0d", i), 32'(e1), 32'(expe[i]));
      chk($sformatf("t5_A%0d", i), 32'(a1), 32'(expa[i]));
      chk($sformatf("t5_busy%0d", i), 32'(b1), 32'(expb[i]));
    end

    // 6: reset mid-DWELL at A=5
    run = 1'b1;
    n = 0;
    while (!(e1 && a1 == 3'd5) && n < 100) begin tick(); n++; end
    tick();
    reset = 1'b1;
    tick();
    chk("t6_A", 32'(a1), 0);
    chk("t6_E", 32'(e1), 0);
    chk("t6_wrap", 32'(w1), 0);
    chk("t6_busy", 32'(b1), 0);
    reset = 1'b0;
    run = 1'b0;
    tick();

    // 6b: no-gap instance keeps E high, A steps every 4 cycles
    run = 1'b1;
    n = 0;
    while (!e0 && n < 5) begin tick(); n++; end
    chk("t6b_first_e", 32'(e0), 1);
    bad = 0;
    for (int k = 0; k < 36; k++) begin
      if (e0 !== 1'b1) bad++;
      if (a0 !== 3'((k / 4) % 8)) bad++;
      if (w0 !== (k == 32)) bad++;
      tick();
    end
    chk("t6b_nogap", 32'(bad), 0);
    run = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
